// File: rtl/adder_pkg.sv
// Shared constants for the 1-bit adder cell and its serial add/subtract lane.
`timescale 10ps/1ps
package adder_pkg;

    localparam int   GATE_DELAY_DEFAULT = 5;

    // Carry-in applied on the first beat of a serial word.
    localparam logic CIN_ADD = 1'b0;
    localparam logic CIN_SUB = 1'b1;

endpackage

// File: rtl/adder_1bit_cell_fa_core.sv
// Primitive-based full adder (g/p form). Gate delays are applied only when
// ADDER_1BIT_GATE_DELAY_EN is defined; the logic function is identical either way.
`timescale 10ps/1ps
module fa_core
    import adder_pkg::*;
#(
    parameter int GATE_DELAY = GATE_DELAY_DEFAULT
) (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic sum_o,
    output logic cout_o
);

    wire g;
    wire p;
    wire pc;
    wire s;
    wire co;

`ifdef ADDER_1BIT_GATE_DELAY_EN
    and #(GATE_DELAY) u_g   (g,  a_i, b_i);
    xor #(GATE_DELAY) u_p   (p,  a_i, b_i);
    xor #(GATE_DELAY) u_s   (s,  p,   c_i);
    and #(GATE_DELAY) u_pc  (pc, p,   c_i);
    or  #(GATE_DELAY) u_co  (co, g,   pc);
`else
    and u_g  (g,  a_i, b_i);
    xor u_p  (p,  a_i, b_i);
    xor u_s  (s,  p,   c_i);
    and u_pc (pc, p,   c_i);
    or  u_co (co, g,   pc);
`endif

    assign sum_o  = s;
    assign cout_o = co;

    if (GATE_DELAY < 0) begin : g_bad_delay
        $error("fa_core: GATE_DELAY must be non-negative");
    end

endmodule

// File: rtl/adder_1bit_cell.sv
// Full-adder cell with a combinational path plus a clocked bit-serial add/sub lane.
// Optional gate delays on the primitives: define ADDER_1BIT_GATE_DELAY_EN.
`timescale 10ps/1ps
module adder_1bit_cell
    import adder_pkg::*;
#(
    parameter int GATE_DELAY = GATE_DELAY_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic sum,
    output logic Cout,
    input  logic s_valid,
    input  logic s_first,
    input  logic s_last,
    input  logic s_sub,
    input  logic s_a,
    input  logic s_b,
    output logic o_valid,
    output logic o_sum,
    output logic o_last,
    output logic o_cout,
    output logic o_ovf
);

    fa_core #(.GATE_DELAY(GATE_DELAY)) u_comb (
        .a_i    (A),
        .b_i    (B),
        .c_i    (Cin),
        .sum_o  (sum),
        .cout_o (Cout)
    );

    logic c_q,     c_d;
    logic sub_q,   sub_d;
    logic valid_q, valid_d;
    logic sum_q,   sum_d;
    logic last_q,  last_d;
    logic cout_q,  cout_d;
    logic ovf_q,   ovf_d;

    logic sub_eff;
    logic cin_eff;
    logic b_eff;
    logic lane_sum;
    logic lane_cout;

    // A first beat restarts the word: carry and mode come from s_sub, not the registers.
    always_comb begin
        sub_eff = s_first ? s_sub : sub_q;
        cin_eff = s_first ? (s_sub ? CIN_SUB : CIN_ADD) : c_q;
        b_eff   = s_b ^ sub_eff;
    end

    fa_core #(.GATE_DELAY(GATE_DELAY)) u_lane (
        .a_i    (s_a),
        .b_i    (b_eff),
        .c_i    (cin_eff),
        .sum_o  (lane_sum),
        .cout_o (lane_cout)
    );

    always_comb begin
        c_d     = c_q;
        sub_d   = sub_q;
        valid_d = 1'b0;
        sum_d   = sum_q;
        last_d  = last_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (s_valid) begin
            c_d     = lane_cout;
            sub_d   = sub_eff;
            valid_d = 1'b1;
            sum_d   = lane_sum;
            last_d  = s_last;
            if (s_last) begin
                cout_d = lane_cout;
                ovf_d  = cin_eff ^ lane_cout;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q     <= 1'b0;
            sub_q   <= 1'b0;
            valid_q <= 1'b0;
            sum_q   <= 1'b0;
            last_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            c_q     <= c_d;
            sub_q   <= sub_d;
            valid_q <= valid_d;
            sum_q   <= sum_d;
            last_q  <= last_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_valid = valid_q;
    assign o_sum   = sum_q;
    assign o_last  = last_q;
    assign o_cout  = cout_q;
    assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_adder_1bit_cell.sv
// Self-checking bench for adder_1bit_cell: combinational sweep plus directed and
// random serial words compared against a word-level arithmetic model.
`timescale 1ns/1ps
module tb_adder_1bit_cell;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic A = 1'b0, B = 1'b0, Cin = 1'b0;
    logic sum, Cout;
    logic s_valid = 1'b0, s_first = 1'b0, s_last = 1'b0, s_sub = 1'b0;
    logic s_a = 1'b0, s_b = 1'b0;
    logic o_valid, o_sum, o_last, o_cout, o_ovf;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    adder_1bit_cell dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .A       (A),
        .B       (B),
        .Cin     (Cin),
        .sum     (sum),
        .Cout    (Cout),
        .s_valid (s_valid),
        .s_first (s_first),
        .s_last  (s_last),
        .s_sub   (s_sub),
        .s_a     (s_a),
        .s_b     (s_b),
        .o_valid (o_valid),
        .o_sum   (o_sum),
        .o_last  (o_last),
        .o_cout  (o_cout),
        .o_ovf   (o_ovf)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Word-level model: n-bit two's-complement add or subtract.
    function automatic void model(input logic [15:0] a, input logic [15:0] b, input int n,
                                  input logic sub, output logic [15:0] res,
                                  output logic cout, output logic ovf);
        longint unsigned mask, av, bv, full;
        logic as, bs, rs;
        mask = (64'd1 << n) - 64'd1;
        av   = longint'(a) & mask;
        bv   = longint'(b) & mask;
        full = sub ? (av + ((~bv) & mask) + 64'd1) : (av + bv);
        res  = 16'(full & mask);
        cout = 1'((full >> n) & 64'd1);
        as   = 1'((av >> (n - 1)) & 64'd1);
        bs   = 1'((bv >> (n - 1)) & 64'd1);
        rs   = 1'((full >> (n - 1)) & 64'd1);
        ovf  = sub ? ((as != bs) && (rs != as)) : ((as == bs) && (rs != as));
    endfunction

    // Drives one word LSB first with an optional idle gap, checking each output
    // beat one cycle after its input beat, then the word result against the model.
    task automatic run_word(input logic [15:0] a, input logic [15:0] b, input int n,
                            input logic sub, input int gap_pos, input int gap_len,
                            input string tag, output logic [15:0] res,
                            output logic cout, output logic ovf);
        logic [15:0] exp_res;
        logic        exp_cout, exp_ovf;
        int          beat, prev;
        res  = '0;
        beat = 0;
        prev = -1;
        for (int slot = 0; slot <= n + gap_len; slot++) begin
            @(negedge clk);
            if (slot > 0) begin
                check({tag, " o_valid"}, 16'(o_valid), 16'(prev >= 0));
                if (prev >= 0) begin
                    res[prev] = o_sum;
                    check({tag, " o_last"}, 16'(o_last), 16'(prev == n - 1));
                end
            end
            if (slot == n + gap_len || (slot >= gap_pos && slot < gap_pos + gap_len)) begin
                s_valid = 1'b0;
                s_first = 1'b0;
                s_last  = 1'b0;
                s_sub   = 1'($urandom);
                prev    = -1;
            end else begin
                s_valid = 1'b1;
                s_first = (beat == 0);
                s_last  = (beat == n - 1);
                s_sub   = (beat == 0) ? sub : 1'($urandom);
                s_a     = a[beat];
                s_b     = b[beat];
                prev    = beat;
                beat++;
            end
        end
        cout = o_cout;
        ovf  = o_ovf;
        model(a, b, n, sub, exp_res, exp_cout, exp_ovf);
        check({tag, " result"}, res, exp_res);
        check({tag, " o_cout"}, 16'(cout), 16'(exp_cout));
        check({tag, " o_ovf"}, 16'(ovf), 16'(exp_ovf));
    endtask

    initial begin
        logic [15:0] res;
        logic        cout, ovf;
        logic [2:0]  abc;
        logic [15:0] ra, rb;
        int          rn;

        // Reset state
        #3;
        check("rst o_valid", 16'(o_valid), 16'd0);
        check("rst o_sum",   16'(o_sum),   16'd0);
        check("rst o_cout",  16'(o_cout),  16'd0);
        check("rst o_ovf",   16'(o_ovf),   16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Combinational sweep, no clock dependence
        for (int i = 0; i < 8; i++) begin
            abc = 3'(i);
            A   = abc[2];
            B   = abc[1];
            Cin = abc[0];
            #1;
            check("comb sum",  16'(sum),  16'((i[2] + i[1] + i[0]) & 1));
            check("comb cout", 16'(Cout), 16'((i[2] + i[1] + i[0]) >> 1));
        end
        A = 1'b1; B = 1'b1; Cin = 1'b0; #1;
        check("comb 110 sum", 16'(sum), 16'd0);
        check("comb 110 cout", 16'(Cout), 16'd1);
        A = 1'b1; B = 1'b0; Cin = 1'b1; #1;
        check("comb 101 sum", 16'(sum), 16'd0);
        check("comb 101 cout", 16'(Cout), 16'd1);

        // Directed serial words
        run_word(16'h5A, 16'hC3, 8, 1'b0, -1, 0, "add5AC3", res, cout, ovf);
        check("add5AC3 const", res, 16'h1D);
        check("add5AC3 cout const", 16'(cout), 16'd1);
        run_word(16'h10, 16'h20, 8, 1'b1, -1, 0, "sub1020", res, cout, ovf);
        check("sub1020 const", res, 16'hF0);
        check("sub1020 cout const", 16'(cout), 16'd0);
        check("sub1020 ovf const", 16'(ovf), 16'd0);
        run_word(16'h7F, 16'h01, 8, 1'b0, -1, 0, "add7F01", res, cout, ovf);
        check("add7F01 const", res, 16'h80);
        check("add7F01 ovf const", 16'(ovf), 16'd1);
        check("add7F01 cout const", 16'(cout), 16'd0);

        // Idle gap of two cycles inside the word
        run_word(16'h5A, 16'hC3, 8, 1'b0, 4, 2, "gap5AC3", res, cout, ovf);
        check("gap5AC3 const", res, 16'h1D);
        check("gap5AC3 hold cout", 16'(o_cout), 16'd1);

        // Reset mid-word: subtract 0xFF-0x00 leaves carry=1, sub=1, o_sum=1
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_first = (i == 0);
            s_last  = 1'b0;
            s_sub   = 1'b1;
            s_a     = 1'b1;
            s_b     = 1'b0;
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_first = 1'b0;
        s_sub   = 1'b0;
        check("pre-rst o_valid", 16'(o_valid), 16'd1);
        check("pre-rst o_sum",   16'(o_sum),   16'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async rst o_valid", 16'(o_valid), 16'd0);
        check("async rst o_sum",   16'(o_sum),   16'd0);
        check("async rst o_last",  16'(o_last),  16'd0);
        check("async rst o_cout",  16'(o_cout),  16'd0);
        check("async rst o_ovf",   16'(o_ovf),   16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // Beat without s_first after reset must see cleared carry and mode
        s_valid = 1'b1;
        s_first = 1'b0;
        s_last  = 1'b1;
        s_a     = 1'b0;
        s_b     = 1'b0;
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        check("post-rst o_valid", 16'(o_valid), 16'd1);
        check("post-rst o_sum",   16'(o_sum),   16'd0);
        check("post-rst o_cout",  16'(o_cout),  16'd0);
        run_word(16'h01, 16'h01, 8, 1'b0, -1, 0, "add0101", res, cout, ovf);
        check("add0101 const", res, 16'h02);

        // s_first mid-word restarts the carry
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_first = (i == 0);
            s_last  = 1'b0;
            s_sub   = 1'b1;
            s_a     = 1'b0;
            s_b     = 1'b1;
        end
        run_word(16'h03, 16'h05, 4, 1'b0, -1, 0, "restart", res, cout, ovf);

        // Single-beat words
        run_word(16'h0, 16'h1, 1, 1'b1, -1, 0, "1b sub", res, cout, ovf);
        run_word(16'h1, 16'h1, 1, 1'b0, -1, 0, "1b add", res, cout, ovf);

        // Random words of random width and mode
        for (int k = 0; k < 24; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rn = int'($urandom_range(1, 16));
            run_word(ra, rb, rn, 1'($urandom), (k % 3 == 0) ? int'($urandom_range(1, 3)) : -1,
                     (k % 3 == 0) ? 1 : 0, "rand", res, cout, ovf);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adder_1bit_cell.md
Name: adder_1bit_cell

Overview:
- Single-bit full-adder cell. Its combinational path is the per-bit sum cell instantiated 64 times inside adder_64bit; adder_64bit supplies each cell's carry-in from its own lookahead chain and leaves the cell's Cout unconnected.
- The cell also contains a clocked bit-serial add/subtract lane. The lane reuses the same full adder, feeds the carry back through a register, and processes one operand bit per cycle, LSB first.

Parameters:
- GATE_DELAY, 5, per-primitive delay in timescale units (10ps); used only when ADDER_1BIT_GATE_DELAY_EN is defined.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- A  input  1  combinational operand bit A.
- B  input  1  combinational operand bit B.
- Cin  input  1  combinational carry-in.
- sum  output  1  combinational sum, A^B^Cin.
- Cout  output  1  combinational carry-out, (A&B)|((A^B)&Cin).
- s_valid  input  1  serial beat valid.
- s_first  input  1  beat is the LSB of a word.
- s_last  input  1  beat is the MSB of a word.
- s_sub  input  1  word is A-B; sampled on the first beat only.
- s_a  input  1  serial operand A bit.
- s_b  input  1  serial operand B bit.
- o_valid  output  1  registered result beat valid.
- o_sum  output  1  registered sum bit.
- o_last  output  1  registered MSB marker.
- o_cout  output  1  final carry-out; meaningful when o_last=1.
- o_ovf  output  1  signed overflow; meaningful when o_last=1.

Behaviour:
- Combinational path:
  - Zero latency; no dependence on clk or rst_n.
  - Built from and/xor/or primitives: g=A&B, p=A^B, sum=p^Cin, Cout=g|(p&Cin).
  - Must match a full adder for all 8 input combinations.
- Serial lane, effective inputs per beat:
  - b_eff = s_b ^ sub_eff.
  - sub_eff = s_sub on a first beat; otherwise the registered sub_q.
  - cin_eff = s_sub on a first beat (1 for subtract, 0 for add); otherwise the carry register c_q.
- Serial lane, on a clock edge with s_valid=1:
  - c_q <= full-adder carry of (s_a, b_eff, cin_eff).
  - sub_q <= sub_eff.
  - o_sum <= full-adder sum.
  - o_valid <= 1; o_last <= s_last.
  - If s_last=1: o_cout <= carry-out; o_ovf <= cin_eff ^ carry-out.
- Serial lane, on a clock edge with s_valid=0: o_valid <= 0; c_q and sub_q hold.
- Latency: exactly one cycle from input beat to output beat. There is no backpressure and the lane is always ready.
- Single-beat word (s_first=1 and s_last=1 together) is a legal 1-bit add or subtract.
- s_first on a beat overrides any in-progress word: the carry restarts. This is not an error.
- Beats after s_last with no s_first continue from c_q; this is chaining, and the bench must not rely on it.
- Reset (rst_n=0, asynchronous): c_q, sub_q, o_valid, o_sum, o_last, o_cout and o_ovf all go to 0 immediately.
  - Reset asserted mid-word aborts the word.
  - Beats arriving after reset with no s_first use c_q=0.
- o_cout and o_ovf hold their value until the next last beat or reset.

Optional Feature:
- Macro ADDER_1BIT_GATE_DELAY_EN.
- Defined: each combinational primitive carries #GATE_DELAY, so sum settles after 2 gate delays and Cout after 3. Registered outputs are unaffected.
- Undefined: all primitives have zero delay; the design is synthesizable as-is.
- Logic function is identical in both cases.

Decomposition:
- Package adder_pkg holds:
  - GATE_DELAY_DEFAULT = 5.
  - The carry-in encodings CIN_ADD = 1'b0 and CIN_SUB = 1'b1.
- One sub-module, fa_core: the primitive-based full adder. It is instantiated twice, once for the combinational path and once for the serial lane.

Test Plan:
- Combinational path: sweep all 8 combinations of A/B/Cin. Required: 0,0,0->sum0 Cout0; 1,1,0->sum0 Cout1; 1,1,1->sum1 Cout1; 1,0,1->sum0 Cout1.
- Serial 8-bit add, 0x5A+0xC3 (first on bit0, last on bit7): o_sum bits form 0x1D, o_cout=1, o_ovf=0. Each output beat appears one cycle after its input beat.
- Serial 8-bit subtract, 0x10-0x20 (s_sub=1): result 0xF0, o_cout=0, o_ovf=0.
- Serial 8-bit add, 0x7F+0x01: result 0x80, o_ovf=1, o_cout=0.
- Reset mid-word:
  - Assert rst_n=0 after beat 3 of a word. All outputs read 0 immediately, without waiting for a clock edge.
  - After release, send a new word 0x01+0x01: result 0x02, o_valid pulses only for driven beats.
- Idle gap: drop s_valid for 2 cycles in the middle of the 0x5A+0xC3 word. o_valid drops for those cycles, c_q holds, and the final result is still 0x1D.
